// File: rtl/bcd_arb_pkg.sv
// Shared types and constants for the round-robin binary-to-BCD converter.
package bcd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

  // Decimal digits needed to print the largest unsigned value of the given width.
  function automatic int min_digits(input int width);
    longint unsigned v;
    int d;
    v = (64'd1 << width) - 64'd1;
    d = 0;
    for (int i = 0; i < 20; i++) begin
      if (v != 64'd0) begin
        v = v / 64'd10;
        d++;
      end
    end
    return (d == 0) ? 1 : d;
  endfunction

endpackage

// File: rtl/bcd_dabble_core.sv
// Iterative shift-add-3 engine: one operand bit per cycle, MSB first.
module bcd_dabble_core
  import bcd_arb_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  start,
  input  logic [WIDTH-1:0]      operand,
  output logic                  done,
  output logic [DIGITS*4-1:0]   digits
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0]    sreg;
  logic [DIGITS*4-1:0] bcd_q;
  logic [DIGITS*4-1:0] adj;
  logic [CW-1:0]       cnt;
  logic                running;

  always_comb begin
    adj = bcd_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= BCD_ADJ_THRESH)
        adj[4*k +: 4] = bcd_q[4*k +: 4] + BCD_ADJ_ADD;
    end
  end

  // done marks the edge that performs the final shift
  assign done   = running && (cnt == CW'(WIDTH-1));
  assign digits = bcd_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      running <= 1'b0;
      cnt     <= '0;
      sreg    <= '0;
      bcd_q   <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      sreg    <= operand;
      bcd_q   <= '0;
    end else if (running) begin
      bcd_q <= {adj[DIGITS*4-2:0], sreg[WIDTH-1]};
      sreg  <= {sreg[WIDTH-2:0], 1'b0};
      cnt   <= cnt + CW'(1);
      if (done)
        running <= 1'b0;
    end
  end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one BCD engine; BCD_SIGNED_EN selects two's-complement operands.
// state | meaning:  IDLE = grant next requester | SHIFT = engine converting | DONE = result held for sink
module bcd_conv_arbiter
  import bcd_arb_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*WIDTH-1:0]     req_data,
  output logic [NREQ-1:0]           req_ready,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [DIGITS*4-1:0]       rsp_bcd,
  output logic                      rsp_neg,
  output logic                      busy
);

  localparam int IDW = $clog2(NREQ);

  if (DIGITS < min_digits(WIDTH)) begin : g_digits_check
    $error("bcd_conv_arbiter: DIGITS too small for WIDTH");
  end

  state_t           state;
  logic [IDW-1:0]   rr;
  logic [IDW-1:0]   gnt;
  logic             gnt_found;
  logic [WIDTH-1:0] gnt_op;
  logic [WIDTH-1:0] core_op;
  logic             core_start;
  logic             core_done;
  int               idx;

  // Search starts just after the last winner so every requester rotates to the top.
  always_comb begin
    gnt       = '0;
    gnt_found = 1'b0;
    gnt_op    = '0;
    idx       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(rr) + k;
      if (idx >= NREQ)
        idx = idx - NREQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt       = IDW'(idx);
        gnt_found = 1'b1;
        gnt_op    = req_data[idx*WIDTH +: WIDTH];
      end
    end
  end

  assign core_start = (state == IDLE) && gnt_found && !clr;
  assign req_ready  = core_start ? (NREQ'(1) << gnt) : '0;
  assign rsp_valid  = (state == DONE);
  assign busy       = (state != IDLE);

`ifdef BCD_SIGNED_EN
  logic neg_q;

  assign core_op = gnt_op[WIDTH-1] ? -gnt_op : gnt_op;
  assign rsp_neg = neg_q;

  always_ff @(posedge clk) begin
    if (clr)
      neg_q <= 1'b0;
    else if (core_start)
      neg_q <= gnt_op[WIDTH-1];
  end
`else
  assign core_op = gnt_op;
  assign rsp_neg = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      state  <= IDLE;
      rr     <= IDW'(NREQ-1);
      rsp_id <= '0;
    end else begin
      case (state)
        IDLE: if (gnt_found) begin
          rr     <= gnt;
          rsp_id <= gnt;
          state  <= SHIFT;
        end
        SHIFT: if (core_done) state <= DONE;
        DONE:  if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  bcd_dabble_core #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_core (
    .clk     (clk),
    .clr     (clr),
    .start   (core_start),
    .operand (core_op),
    .done    (core_done),
    .digits  (rsp_bcd)
  );

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Self-checking bench for bcd_conv_arbiter with an arithmetic reference model.
module tb_bcd_conv_arbiter;

  localparam int NREQ = 4;
  localparam int WIDTH = 32;
  localparam int DIGITS = 10;
  localparam int LAT = WIDTH + 1;

  logic         clk = 1'b0;
  logic         clr;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [1:0]   rsp_id;
  logic [39:0]  rsp_bcd;
  logic         rsp_neg;
  logic         busy;

  int vectors = 0;
  int miscompares = 0;
  int model_rr = NREQ - 1;

  bcd_conv_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk(clk), .clr(clr), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_bcd(rsp_bcd), .rsp_neg(rsp_neg), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [39:0] exp_bcd(input logic [31:0] op);
    longint unsigned v;
    logic [39:0] r;
`ifdef BCD_SIGNED_EN
    v = op[31] ? (64'h1_0000_0000 - longint'(op)) : longint'(op);
`else
    v = longint'(op);
`endif
    r = '0;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic exp_neg(input logic [31:0] op);
`ifdef BCD_SIGNED_EN
    return op[31];
`else
    return 1'b0;
`endif
  endfunction

  function automatic int exp_grant(input logic [3:0] mask);
    for (int k = 1; k <= NREQ; k++)
      if (mask[(model_rr + k) % NREQ]) return (model_rr + k) % NREQ;
    return -1;
  endfunction

  task automatic issue(input logic [3:0] mask, input logic [127:0] data, input bit drop,
                       output logic [3:0] g, output bit tmo);
    req_valid = mask;
    req_data = data;
    g = 4'b0;
    tmo = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready !== 4'b0) begin
        g = req_ready;
        tmo = 1'b0;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (drop) req_valid = 4'b0;
  endtask

  task automatic wait_rsp(output int lat, output bit tmo);
    lat = 0;
    tmo = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid === 1'b1) begin
        tmo = 1'b0;
        break;
      end
    end
  endtask

  task automatic accept(input int delay);
    repeat (delay) @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    model_rr = NREQ - 1;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    req_valid = 4'b1111;
    req_data = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (req_ready !== 4'b0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctl: ready=%b valid=%b busy=%b want 0000/0/0", req_ready, rsp_valid, busy);
    end
    vectors++;
    if (rsp_bcd !== 40'h0 || rsp_id !== 2'd0 || rsp_neg !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_rsp: bcd=%h id=%0d neg=%b want 0/0/0", rsp_bcd, rsp_id, rsp_neg);
    end
    @(posedge clk);
    #1;
    clr = 1'b0;
    req_valid = 4'b0;
    model_rr = NREQ - 1;
  endtask

  task automatic test_single_max();
    logic [3:0] g;
    bit tmo;
    int lat;
    issue(4'b0001, {96'h0, 32'hFFFF_FFFF}, 1'b1, g, tmo);
    model_rr = 0;
    vectors++;
    if (tmo || g !== 4'b0001) begin
      miscompares++;
      $display("FAIL single_grant: got %b want 0001", g);
    end
    wait_rsp(lat, tmo);
    vectors++;
    if (tmo || lat != LAT) begin
      miscompares++;
      $display("FAIL single_latency: got %0d want %0d", lat, LAT);
    end
    vectors++;
    if (rsp_bcd !== exp_bcd(32'hFFFF_FFFF) || rsp_id !== 2'd0 || rsp_neg !== exp_neg(32'hFFFF_FFFF)) begin
      miscompares++;
      $display("FAIL single_result: bcd=%h id=%0d neg=%b want %h/0/%b", rsp_bcd, rsp_id, rsp_neg,
               exp_bcd(32'hFFFF_FFFF), exp_neg(32'hFFFF_FFFF));
    end
    accept(0);
  endtask

  task automatic test_round_robin();
    logic [3:0] g;
    logic [127:0] data;
    bit tmo;
    int lat, eg;
    int order[5] = '{0, 1, 2, 3, 0};
    pulse_clr();
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 4; j++) data[32*j +: 32] = $urandom;
      eg = exp_grant(4'b1111);
      issue(4'b1111, data, 1'b0, g, tmo);
      model_rr = eg;
      vectors++;
      if (tmo || eg != order[i] || g !== (4'b0001 << eg)) begin
        miscompares++;
        $display("FAIL rr_grant[%0d]: got %b want %b", i, g, 4'b0001 << order[i]);
      end
      wait_rsp(lat, tmo);
      vectors++;
      if (tmo || lat != LAT || rsp_id !== 2'(eg) || rsp_bcd !== exp_bcd(data[32*eg +: 32])) begin
        miscompares++;
        $display("FAIL rr_rsp[%0d]: lat=%0d id=%0d bcd=%h want %0d/%0d/%h", i, lat, rsp_id, rsp_bcd,
                 LAT, eg, exp_bcd(data[32*eg +: 32]));
      end
      accept(0);
    end
    req_valid = 4'b0;
  endtask

  task automatic test_hold();
    logic [3:0] g;
    logic [127:0] data;
    logic [39:0] eb;
    bit tmo;
    int lat, eg;
    for (int j = 0; j < 4; j++) data[32*j +: 32] = $urandom;
    eg = exp_grant(4'b0010);
    issue(4'b0010, data, 1'b1, g, tmo);
    model_rr = eg;
    wait_rsp(lat, tmo);
    eb = exp_bcd(data[63:32]);
    req_valid = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      vectors++;
      if (tmo || rsp_valid !== 1'b1 || rsp_bcd !== eb || rsp_id !== 2'd1 || req_ready !== 4'b0) begin
        miscompares++;
        $display("FAIL hold[%0d]: valid=%b bcd=%h id=%0d ready=%b want 1/%h/1/0000", c,
                 rsp_valid, rsp_bcd, rsp_id, req_ready, eb);
      end
    end
    req_valid = 4'b0;
    accept(0);
  endtask

  task automatic test_clr_mid();
    logic [3:0] g;
    logic [127:0] data;
    bit tmo;
    int lat;
    issue(4'b0001, {96'h0, 32'($urandom)}, 1'b1, g, tmo);
    repeat (15) @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL clr_mid_busy: got %b want 1", busy);
    end
    data = '0;
    data[95:64] = 32'd12345;
    req_data = data;
    req_valid = 4'b0100;
    clr = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    vectors++;
    if (req_ready !== 4'b0 || busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_bcd !== 40'h0) begin
      miscompares++;
      $display("FAIL clr_mid_state: ready=%b busy=%b valid=%b bcd=%h want 0000/0/0/0",
               req_ready, busy, rsp_valid, rsp_bcd);
    end
    @(posedge clk);
    #1;
    clr = 1'b0;
    model_rr = NREQ - 1;
    issue(4'b0100, data, 1'b1, g, tmo);
    model_rr = 2;
    vectors++;
    if (tmo || g !== 4'b0100) begin
      miscompares++;
      $display("FAIL clr_mid_grant: got %b want 0100", g);
    end
    wait_rsp(lat, tmo);
    vectors++;
    if (tmo || lat != LAT || rsp_bcd !== 40'h00_0001_2345 || rsp_id !== 2'd2) begin
      miscompares++;
      $display("FAIL clr_mid_rsp: lat=%0d bcd=%h id=%0d want %0d/0000012345/2", lat, rsp_bcd, rsp_id, LAT);
    end
    accept(0);
  endtask

  task automatic test_sign_vec();
    logic [3:0] g;
    bit tmo;
    int lat;
    logic [39:0] eb;
    logic en;
`ifdef BCD_SIGNED_EN
    eb = 40'h00_0000_0123;
    en = 1'b1;
`else
    eb = 40'h42_9496_7173;
    en = 1'b0;
`endif
    issue(4'b1000, {32'hFFFF_FF85, 96'h0}, 1'b1, g, tmo);
    model_rr = 3;
    wait_rsp(lat, tmo);
    vectors++;
    if (tmo || rsp_bcd !== eb || rsp_neg !== en || rsp_id !== 2'd3) begin
      miscompares++;
      $display("FAIL sign_vec: bcd=%h neg=%b id=%0d want %h/%b/3", rsp_bcd, rsp_neg, rsp_id, eb, en);
    end
    accept(1);
  endtask

  task automatic test_zero_nine();
    logic [3:0] g;
    bit tmo;
    int lat;
    logic [31:0] vals[2] = '{32'd0, 32'd9};
    for (int i = 0; i < 2; i++) begin
      issue(4'b0001, {96'h0, vals[i]}, 1'b1, g, tmo);
      model_rr = 0;
      wait_rsp(lat, tmo);
      vectors++;
      if (tmo || rsp_bcd !== 40'(vals[i]) || rsp_neg !== 1'b0) begin
        miscompares++;
        $display("FAIL zero_nine[%0d]: bcd=%h neg=%b want %h/0", i, rsp_bcd, rsp_neg, 40'(vals[i]));
      end
      accept(0);
    end
  endtask

  task automatic test_random();
    logic [3:0] g, mask;
    logic [127:0] data;
    logic [31:0] op;
    bit tmo;
    int lat, eg;
    for (int i = 0; i < 30; i++) begin
      mask = 4'($urandom_range(1, 15));
      for (int j = 0; j < 4; j++) begin
        case ($urandom_range(0, 7))
          0: data[32*j +: 32] = 32'h8000_0000;
          1: data[32*j +: 32] = 32'hFFFF_FFFF;
          2: data[32*j +: 32] = 32'd0;
          default: data[32*j +: 32] = $urandom;
        endcase
      end
      eg = exp_grant(mask);
      issue(mask, data, 1'b1, g, tmo);
      model_rr = eg;
      op = data[32*eg +: 32];
      vectors++;
      if (tmo || g !== (4'b0001 << eg)) begin
        miscompares++;
        $display("FAIL rand_grant[%0d]: mask=%b got %b want %b", i, mask, g, 4'b0001 << eg);
      end
      wait_rsp(lat, tmo);
      vectors++;
      if (tmo || lat != LAT || rsp_id !== 2'(eg) || rsp_bcd !== exp_bcd(op) || rsp_neg !== exp_neg(op)) begin
        miscompares++;
        $display("FAIL rand_rsp[%0d]: op=%h lat=%0d id=%0d bcd=%h neg=%b want %0d/%0d/%h/%b", i, op,
                 lat, rsp_id, rsp_bcd, rsp_neg, LAT, eg, exp_bcd(op), exp_neg(op));
      end
      accept($urandom_range(0, 3));
    end
  endtask

  initial begin
    clr = 1'b1;
    req_valid = 4'b0;
    req_data = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_single_max();
    test_round_robin();
    test_hold();
    test_clr_mid();
    test_sign_vec();
    test_zero_nine();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
